// File: rtl/spike_encoder.sv
// spike_encoder: buffers one spiketime vector and replays it as PW-wide temporal pulses over one gamma wave.
// Optional macro SPIKE_ENCODER_WAVE_CNT_EN adds a saturating completed-wave counter output (wave_cnt).
module spike_encoder #(
    parameter int P         = 4,
    parameter int VRES      = 3,
    parameter int WRES      = 3,
    parameter int GAMMA_LEN = 24
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [P-1:0][VRES-1:0] in_values,
    input  logic [P-1:0]           in_mask,
    output logic [P-1:0]           input_spikes,
    output logic                   grst,
    output logic                   busy
`ifdef SPIKE_ENCODER_WAVE_CNT_EN
    ,
    output logic [15:0]            wave_cnt
`endif
);
    localparam int PW = 2 ** WRES;
    localparam int CW = $clog2(GAMMA_LEN);
    localparam logic [CW-1:0] C_LAST = CW'(GAMMA_LEN - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW:0]   PW_C   = (CW + 1)'(PW);
    localparam logic [CW:0]   ONE_W  = (CW + 1)'(1);

    // The latest pulse must end before the wave does, so every lane fits in one wave.
    generate
        if (GAMMA_LEN < (2 ** VRES) + PW + 1) begin : g_bad_gamma
            $error("spike_encoder: GAMMA_LEN must be at least 2**VRES + 2**WRES + 1");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        WAVE = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CW-1:0]          r_c;
    logic [CW-1:0]          w_c_next;
    logic                   w_load;
    logic                   w_accept;
    logic                   w_buf_full_next;

    logic                   r_buf_full;
    logic                   r_in_ready;
    logic [P-1:0][VRES-1:0] r_buf_values;
    logic [P-1:0]           r_buf_mask;
    logic [P-1:0][VRES-1:0] r_act_values;
    logic [P-1:0]           r_act_mask;

    // in_ready is only ever high while the buffer is empty, so accept and load never coincide.
    assign w_accept        = in_valid && r_in_ready;
    assign w_buf_full_next = (r_buf_full && !w_load) || w_accept;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= IDLE;
            r_c     <= '0;
        end else begin
            r_state <= w_state_next;
            r_c     <= w_c_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_c_next     = r_c;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_buf_full) begin
                    w_state_next = WAVE;
                    w_c_next     = '0;
                    w_load       = 1'b1;
                end
            end
            WAVE: begin
                if (r_c == C_LAST) begin
                    w_c_next = '0;
                    if (r_buf_full) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_c_next = r_c + C_ONE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_c_next     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_buf_full   <= 1'b0;
            r_in_ready   <= 1'b0;
            r_buf_values <= '0;
            r_buf_mask   <= '0;
            r_act_values <= '0;
            r_act_mask   <= '0;
        end else begin
            r_buf_full <= w_buf_full_next;
            r_in_ready <= ~w_buf_full_next;
            if (w_accept) begin
                r_buf_values <= in_values;
                r_buf_mask   <= in_mask;
            end
            if (w_load) begin
                r_act_values <= r_buf_values;
                r_act_mask   <= r_buf_mask;
            end
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = (r_state == WAVE);
    assign grst     = (r_state == WAVE) && (r_c == '0);

    // Each lane fires for PW cycles starting one cycle after its spiketime.
    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_lane
            logic [CW:0] w_lo;
            logic [CW:0] w_hi;
            logic [CW:0] w_c_ext;
            assign w_c_ext = {1'b0, r_c};
            assign w_lo    = {{(CW + 1 - VRES){1'b0}}, r_act_values[gi]} + ONE_W;
            assign w_hi    = w_lo + PW_C;
            assign input_spikes[gi] = (r_state == WAVE) && r_act_mask[gi]
                                      && (w_c_ext >= w_lo) && (w_c_ext < w_hi);
        end
    endgenerate

`ifdef SPIKE_ENCODER_WAVE_CNT_EN
    logic [15:0] r_wave_cnt;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wave_cnt <= '0;
        end else if ((r_state == WAVE) && (r_c == C_LAST) && (r_wave_cnt != 16'hFFFF)) begin
            r_wave_cnt <= r_wave_cnt + 16'd1;
        end
    end

    assign wave_cnt = r_wave_cnt;
`endif

endmodule

// File: tb/tb_spike_encoder.sv
// tb_spike_encoder: random and directed vectors, scoreboard of expected waves, per-cycle monitor.
// Builds with or without SPIKE_ENCODER_WAVE_CNT_EN.
module tb_spike_encoder;
    localparam int P    = 4;
    localparam int VRES = 3;
    localparam int WRES = 3;
    localparam int G    = 24;
    localparam int PW   = 2 ** WRES;

    logic                   clk = 1'b0;
    logic                   rstb = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [P-1:0][VRES-1:0] in_values = '0;
    logic [P-1:0]           in_mask = '0;
    logic [P-1:0]           input_spikes;
    logic                   grst;
    logic                   busy;
`ifdef SPIKE_ENCODER_WAVE_CNT_EN
    logic [15:0]            wave_cnt;
`endif

    always #5 clk = ~clk;

    spike_encoder #(.P(P), .VRES(VRES), .WRES(WRES), .GAMMA_LEN(G)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_values    (in_values),
        .in_mask      (in_mask),
        .input_spikes (input_spikes),
        .grst         (grst),
        .busy         (busy)
`ifdef SPIKE_ENCODER_WAVE_CNT_EN
        ,
        .wave_cnt     (wave_cnt)
`endif
    );

    typedef struct {
        logic [P-1:0][VRES-1:0] v;
        logic [P-1:0]           m;
        int                     start;
    } wave_t;

    wave_t       exp_q[$];
    wave_t       cur;
    bit          cur_valid = 0;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          ready_m = 0;
    int          buf_until = 0;
    int          last_start = -1000;
    logic [15:0] cnt_m = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    // Predictor: a vector accepted in cycle k waves at max(k+2, previous start + G)
    // and occupies the buffer until the cycle before its wave starts.
    always @(posedge clk) begin : predictor
        wave_t w;
        if (!rstb) begin
            exp_q.delete();
            ready_m    = 0;
            buf_until  = 0;
            last_start = -1000;
        end else if (in_valid && ready_m) begin
            w.v        = in_values;
            w.m        = in_mask;
            w.start    = (cyc + 2 > last_start + G) ? cyc + 2 : last_start + G;
            last_start = w.start;
            buf_until  = w.start - 1;
            exp_q.push_back(w);
        end
        cyc = cyc + 1;
        if (rstb) ready_m = (cyc > buf_until);
    end

    always @(negedge clk) begin : monitor
        logic [P-1:0] exp_sp;
        logic         exp_grst;
        logic         exp_busy;
        int           c;
        if (!rstb) begin
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_spikes", 32'(input_spikes), 32'd0);
            chk("rst_grst", 32'(grst), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
`ifdef SPIKE_ENCODER_WAVE_CNT_EN
            chk("rst_wave_cnt", 32'(wave_cnt), 32'd0);
`endif
            cur_valid = 0;
            cnt_m     = '0;
        end else begin
            exp_grst = (exp_q.size() > 0) && (exp_q[0].start == cyc);
            chk("grst", 32'(grst), 32'(exp_grst));
            if ((exp_q.size() > 0) && (grst === 1'b1 || exp_q[0].start <= cyc)) begin
                cur       = exp_q.pop_front();
                cur_valid = 1;
                $display("wave start=%0d values=%h mask=%b", cur.start, cur.v, cur.m);
            end
            c        = cyc - cur.start;
            exp_busy = cur_valid && (c >= 0) && (c < G);
            exp_sp   = '0;
            if (exp_busy) begin
                for (int j = 0; j < P; j++) begin
                    if (cur.m[j] && (c >= 1 + int'(cur.v[j])) && (c < 1 + int'(cur.v[j]) + PW))
                        exp_sp[j] = 1'b1;
                end
            end
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("spikes", 32'(input_spikes), 32'(exp_sp));
            chk("in_ready", 32'(in_ready), 32'(ready_m));
`ifdef SPIKE_ENCODER_WAVE_CNT_EN
            chk("wave_cnt", 32'(wave_cnt), 32'(cnt_m));
            if (exp_busy && (c == G - 1) && (cnt_m != 16'hFFFF)) cnt_m = cnt_m + 16'd1;
`endif
        end
    end

    function automatic logic [P-1:0][VRES-1:0] pack4(int a, int b, int c, int d);
        logic [P-1:0][VRES-1:0] r;
        r[0] = VRES'(a);
        r[1] = VRES'(b);
        r[2] = VRES'(c);
        r[3] = VRES'(d);
        return r;
    endfunction

    // Entered and left just after a rising edge; in_ready is read only to pace the handshake.
    task automatic send(input logic [P-1:0][VRES-1:0] v, input logic [P-1:0] m, input bit scramble);
        int n;
        bit done;
        n         = 0;
        done      = 0;
        in_valid  = 1'b1;
        in_values = v;
        in_mask   = m;
        while (!done) begin
            @(negedge clk);
            done = (in_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 300) begin
                checks++;
                errors++;
                $display("FAIL send_timeout cycle %0d: got no acceptance after %0d cycles, required acceptance", cyc, n);
                done = 1;
            end else if (!done && scramble) begin
                in_values = (P * VRES)'($urandom);
                in_mask   = P'($urandom);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rstb = 1'b0;
        repeat (4) @(posedge clk);
        #1 rstb = 1'b1;
        @(posedge clk);
        #1;

        send(pack4(0, 3, 7, 5), 4'b1111, 0);
        idle(30);
        send(pack4(2, 2, 2, 2), 4'b0101, 0);
        idle(30);

        send(pack4(1, 4, 6, 0), 4'b1011, 0);
        send(pack4(7, 7, 0, 3), 4'b1111, 0);
        idle(60);

        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 30));
            send((P * VRES)'($urandom), P'($urandom), 1);
        end
        idle(60);

        // Reset at c=9 of a wave while a second vector waits in the buffer.
        send(pack4(0, 1, 2, 3), 4'b1111, 0);
        send(pack4(4, 5, 6, 7), 4'b1111, 0);
        repeat (8) @(posedge clk);
        #2 rstb = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstb = 1'b1;
        idle(40);
        send(pack4(3, 0, 5, 1), 4'b1110, 0);
        idle(35);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
